// File: rtl/seg_scan_ctrl.sv
// Purpose : four-digit multiplexed seven-segment scanner with frame-synchronous data load.
// Latency : new data shows in the first digit-0 DRIVE after the next frame boundary.
// Backpressure: ready drops after a load is taken and rises after the frame boundary applies it.
//
// Ports:
//   clk         single clock, rising edge
//   rst         synchronous active-high reset
//   load        request to display data_in (taken only while ready=1)
//   data_in     four hex nibbles, [3:0] is the rightmost digit
//   ready       high while no load is pending
//   seg         segments a..g on [0]..[6], active-low
//   ga          digit anodes, active-low, [0] is the rightmost digit
//   frame_tick  one-cycle pulse in the cycle after each frame boundary
//
// Optional feature: define SEG_LEADING_ZERO_BLANK_EN to blank leading zero digits
// (digit 0 is never blanked; anode timing is unchanged).

module seg_scan_ctrl #(
   parameter int DIGIT_CYCLES = 50000,
   parameter int GAP_CYCLES   = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [15:0] data_in,
   output logic        ready,
   output logic [6:0]  seg,
   output logic [3:0]  ga,
   output logic        frame_tick
);

   // One counter serves both phases, so it must hold the larger terminal count.
   localparam int MAXC = (DIGIT_CYCLES > GAP_CYCLES) ? DIGIT_CYCLES : GAP_CYCLES;
   localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

   localparam logic [CW-1:0] DIGIT_LAST = CW'(DIGIT_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LAST   = (GAP_CYCLES > 0) ? CW'(GAP_CYCLES - 1) : '0;
   localparam logic [CW-1:0] CNT_ONE    = CW'(1);

   typedef enum logic {
      ST_GAP   = 1'b0,
      ST_DRIVE = 1'b1
   } state_t;

   state_t        state_q, state_d;
   logic [1:0]    idx_q, idx_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [15:0]   display_q, display_d;
   logic [15:0]   pend_q, pend_d;
   logic          pend_vld_q, pend_vld_d;
   logic          frame_tick_q, frame_tick_d;
   logic          frame_end;

   // Scan sequencing.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      cnt_d     = cnt_q;
      frame_end = 1'b0;
      case (state_q)
         ST_GAP: begin
            // With no blanking configured the gap state only lasts the single
            // cycle that follows reset.
            if (GAP_CYCLES == 0 || cnt_q == GAP_LAST) begin
               state_d = ST_DRIVE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         ST_DRIVE: begin
            if (cnt_q == DIGIT_LAST) begin
               cnt_d     = '0;
               idx_d     = idx_q + 2'd1;
               frame_end = (idx_q == 2'd3);
               state_d   = (GAP_CYCLES == 0) ? ST_DRIVE : ST_GAP;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = ST_GAP;
            cnt_d   = '0;
         end
      endcase
   end

   // Load handshake. A load can only be taken while nothing is pending, so a
   // load seen on a boundary cycle never collides with the copy: it is held
   // until the following boundary.
   always_comb begin
      display_d    = display_q;
      pend_d       = pend_q;
      pend_vld_d   = pend_vld_q;
      frame_tick_d = frame_end;
      if (frame_end && pend_vld_q) begin
         display_d  = pend_q;
         pend_vld_d = 1'b0;
      end
      if (load && !pend_vld_q) begin
         pend_d     = data_in;
         pend_vld_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_GAP;
         idx_q        <= 2'd0;
         cnt_q        <= '0;
         display_q    <= 16'h0000;
         pend_q       <= 16'h0000;
         pend_vld_q   <= 1'b0;
         frame_tick_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         cnt_q        <= cnt_d;
         display_q    <= display_d;
         pend_q       <= pend_d;
         pend_vld_q   <= pend_vld_d;
         frame_tick_q <= frame_tick_d;
      end
   end

   assign ready      = ~pend_vld_q;
   assign frame_tick = frame_tick_q;

   // Segment decode, active-low, bit order g..a.
   logic [3:0] nib;
   logic [6:0] dec;

   always_comb begin
      nib = display_q[{idx_q, 2'b00} +: 4];
      case (nib)
         4'h0:    dec = 7'b1000000;
         4'h1:    dec = 7'b1111001;
         4'h2:    dec = 7'b0100100;
         4'h3:    dec = 7'b0110000;
         4'h4:    dec = 7'b0011001;
         4'h5:    dec = 7'b0010010;
         4'h6:    dec = 7'b0000010;
         4'h7:    dec = 7'b1111000;
         4'h8:    dec = 7'b0000000;
         4'h9:    dec = 7'b0010000;
         4'hA:    dec = 7'b0001000;
         4'hB:    dec = 7'b0000011;
         4'hC:    dec = 7'b1000110;
         4'hD:    dec = 7'b0100001;
         4'hE:    dec = 7'b0000110;
         default: dec = 7'b0001110;
      endcase
   end

`ifdef SEG_LEADING_ZERO_BLANK_EN
   // A digit is a leading zero when it and every digit to its left are zero.
   logic lead_blank;

   always_comb begin
      case (idx_q)
         2'd1:    lead_blank = (display_q[15:4]  == 12'h000);
         2'd2:    lead_blank = (display_q[15:8]  == 8'h00);
         2'd3:    lead_blank = (display_q[15:12] == 4'h0);
         default: lead_blank = 1'b0;
      endcase
   end
`endif

   always_comb begin
      ga  = 4'b1111;
      seg = 7'b1111111;
      if (state_q == ST_DRIVE) begin
         ga = ~(4'b0001 << idx_q);
`ifdef SEG_LEADING_ZERO_BLANK_EN
         seg = lead_blank ? 7'b1111111 : dec;
`else
         seg = dec;
`endif
      end
   end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
module tb_seg_scan_ctrl;

   localparam int D    = 4;
   localparam int G    = 2;
   localparam int NCYC = 1500;

   logic        clk = 1'b0;
   logic        rst;
   logic        load;
   logic [15:0] data_in;
   logic        ready, frame_tick;
   logic [6:0]  seg;
   logic [3:0]  ga;
   logic        ready0, frame_tick0;
   logic [6:0]  seg0;
   logic [3:0]  ga0;

   always #5 clk = ~clk;

   seg_scan_ctrl #(.DIGIT_CYCLES(D), .GAP_CYCLES(G)) u_dut (
      .clk(clk), .rst(rst), .load(load), .data_in(data_in),
      .ready(ready), .seg(seg), .ga(ga), .frame_tick(frame_tick)
   );

   // No-gap instance: only the scan pattern is of interest, display stays zero.
   seg_scan_ctrl #(.DIGIT_CYCLES(D), .GAP_CYCLES(0)) u_dut0 (
      .clk(clk), .rst(rst), .load(1'b0), .data_in(16'h0000),
      .ready(ready0), .seg(seg0), .ga(ga0), .frame_tick(frame_tick0)
   );

   typedef struct packed {
      logic [3:0] ga;
      logic [6:0] seg;
      logic       rdy;
      logic       ft;
      logic [3:0] ga0;
      logic [6:0] seg0;
      logic       rdy0;
      logic       ft0;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   logic [6:0] hex_tab [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };

   // Reference model: position in the frame is pure arithmetic on the number
   // of cycles since reset. With no gap the very first cycle is the reset gap.
   function automatic int cur_digit(input int tt, input int g);
      int off, p;
      off = (g == 0) ? 1 : 0;
      if (tt < off) return -1;
      p = (tt - off) % (4 * (g + D));
      if ((p % (g + D)) < g) return -1;
      return p / (g + D);
   endfunction

   function automatic bit is_boundary(input int tt, input int g);
      int off;
      off = (g == 0) ? 1 : 0;
      if (tt < off) return 1'b0;
      return ((tt - off) % (4 * (g + D))) == (4 * (g + D) - 1);
   endfunction

   function automatic void model_out(input int tt, input int g, input logic [15:0] disp,
                                     output logic [3:0] ga_o, output logic [6:0] seg_o);
      int d;
      logic [3:0] n;
      ga_o  = 4'hF;
      seg_o = 7'h7F;
      d = cur_digit(tt, g);
      if (d < 0) return;
      ga_o[d] = 1'b0;
      n = 4'(disp >> (4 * d));
      seg_o = hex_tab[n];
`ifdef SEG_LEADING_ZERO_BLANK_EN
      if (d != 0 && (disp >> (4 * d)) == 16'h0000) seg_o = 7'h7F;
`endif
   endfunction

   task automatic chk(input string name, input int cyc, input logic [6:0] got, input logic [6:0] expv);
      checks++;
      if (got !== expv) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%b exp=%b", name, cyc, got, expv);
      end
   endtask

   // Monitor: every cycle the DUT presents a fresh output set.
   int mon_cyc = 0;
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("ga",          mon_cyc, {3'b0, ga} << 0,     {3'b0, e.ga});
            chk("seg",         mon_cyc, seg,                 e.seg);
            chk("ready",       mon_cyc, {6'b0, ready},       {6'b0, e.rdy});
            chk("frame_tick",  mon_cyc, {6'b0, frame_tick},  {6'b0, e.ft});
            chk("ga_nogap",    mon_cyc, {3'b0, ga0},         {3'b0, e.ga0});
            chk("seg_nogap",   mon_cyc, seg0,                e.seg0);
            chk("ready_nogap", mon_cyc, {6'b0, ready0},      {6'b0, e.rdy0});
            chk("ftick_nogap", mon_cyc, {6'b0, frame_tick0}, {6'b0, e.ft0});
            mon_cyc++;
         end
      end
   end

   // Driver + model.
   int          t;
   logic [15:0] m_disp, m_pend;
   bit          m_pv, m_ft, m_ft0;
   bit          mid_rst_done = 1'b0;

   initial begin
      exp_t        e;
      logic [15:0] mask;
      bit          b, b0;
      rst     = 1'b1;
      load    = 1'b0;
      data_in = 16'h0000;
      repeat (3) @(posedge clk);
      #1;
      t = 0; m_disp = 16'h0; m_pend = 16'h0; m_pv = 1'b0; m_ft = 1'b0; m_ft0 = 1'b0;

      for (int cyc = 0; cyc < NCYC; cyc++) begin
         model_out(t, G, m_disp, e.ga, e.seg);
         e.rdy = !m_pv;
         e.ft  = m_ft;
         model_out(t, 0, 16'h0000, e.ga0, e.seg0);
         e.rdy0 = 1'b1;
         e.ft0  = m_ft0;
         exp_q.push_back(e);

         rst     = 1'b0;
         load    = 1'b0;
         data_in = 16'(($urandom));
         if (cyc == 0) begin
            load = 1'b1; data_in = 16'h1238;
         end else if (cyc >= 1 && cyc <= 20) begin
            load = 1'b1; data_in = 16'hFFFF;          // must be ignored while busy
         end else if (cyc == 60) begin
            load = 1'b1; data_in = 16'h0042;
         end else if (cyc == 120) begin
            load = 1'b1; data_in = 16'h0000;
         end else if (cyc >= 170) begin
            case ($urandom_range(0, 3))
               0:       mask = 16'hFFFF;
               1:       mask = 16'h0FFF;
               2:       mask = 16'h00FF;
               default: mask = 16'h000F;
            endcase
            data_in = 16'($urandom) & mask;
            load    = ($urandom_range(0, 3) == 0);
            if (!mid_rst_done && cyc >= 400 && m_pv && cur_digit(t, G) == 2) begin
               rst = 1'b1;
               load = 1'b0;
               mid_rst_done = 1'b1;
            end
         end

         @(posedge clk);
         if (rst) begin
            t = 0; m_disp = 16'h0; m_pv = 1'b0; m_ft = 1'b0; m_ft0 = 1'b0;
         end else begin
            b  = is_boundary(t, G);
            b0 = is_boundary(t, 0);
            if (b && m_pv) begin
               m_disp = m_pend;
               m_pv   = 1'b0;
            end else if (load && !m_pv) begin
               m_pend = data_in;
               m_pv   = 1'b1;
            end
            m_ft  = b;
            m_ft0 = b0;
            t++;
         end
         #1;
      end

      @(negedge clk);
      #1;
      if (!mid_rst_done) begin
         errors++;
         $display("FAIL mid_frame_reset never issued");
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter DIGIT_CYCLES, default 50000, clocks each digit is driven (>=1).
REQ-002 SHALL have parameter GAP_CYCLES, default 16, all-off blanking clocks before each digit (>=0).
REQ-003 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port load  input  1  request to display data_in.
REQ-006 SHALL have port data_in  input  16  four hex nibbles; [3:0] is the rightmost digit.
REQ-007 SHALL have port ready  output  1  high when a load is accepted.
REQ-008 SHALL have port seg  output  7  segments, active-low; seg[0]=a ... seg[6]=g.
REQ-009 SHALL have port ga  output  4  digit anodes, active-low; ga[0] is the rightmost digit.
REQ-010 SHALL have port frame_tick  output  1  one-cycle pulse per completed scan frame.

Function
REQ-011 SHALL run a two-state scan FSM, GAP and DRIVE, with a 2-bit digit index idx.
REQ-012 In GAP, SHALL drive ga=4'b1111 and seg=7'b1111111 for GAP_CYCLES clocks, then enter DRIVE; with GAP_CYCLES=0, GAP SHALL be skipped.
REQ-013 In DRIVE, SHALL hold ga[idx]=0 with the others 1, and drive seg with the hex decode of display nibble idx, for DIGIT_CYCLES clocks.
REQ-014 At the end of DRIVE, SHALL increment idx modulo 4 and return to GAP (or to DRIVE if GAP_CYCLES=0).
REQ-015 A frame SHALL be 4*(GAP_CYCLES+DIGIT_CYCLES) clocks; the frame boundary is the last DRIVE cycle with idx=3.
REQ-016 Hex decode SHALL be the standard active-low table: 0=1000000, 1=1111001, 2=0100100, 4=0011001, 8=0000000, F=0001110 (g..a).
REQ-017 When load=1 and ready=1, SHALL capture data_in into a pending register; ready SHALL go low on the next cycle.
REQ-018 load while ready=0 SHALL be ignored; the pending value is not modified.
REQ-019 At the frame boundary, if pending is valid, SHALL copy it to the display register; ready SHALL return high on the next cycle.
REQ-020 A load accepted on the frame-boundary cycle itself SHALL be applied at the following boundary, not the current one.
REQ-021 New data SHALL first appear on seg in the first DRIVE of digit 0 after the copy.
REQ-022 frame_tick SHALL pulse high for exactly the one cycle following each frame boundary, and never in the cycle following reset release.
REQ-023 Cycle counters SHALL be sized to hold max(DIGIT_CYCLES,GAP_CYCLES)-1 without overflow.

Reset
REQ-024 While rst=1 at a clock edge, SHALL set: state=GAP, idx=0, counter=0, display=16'h0000, pending invalid, ready=1, ga=4'b1111, seg=7'b1111111, frame_tick=0.
REQ-025 rst asserted mid-frame SHALL discard any pending load and apply REQ-024 on the next edge.

Configuration
REQ-026 Macro SEG_LEADING_ZERO_BLANK_EN SHALL control leading-zero blanking.
REQ-027 With SEG_LEADING_ZERO_BLANK_EN defined, during DRIVE of any digit whose nibble and all higher nibbles are zero, SHALL drive seg=7'b1111111 and keep the ga timing unchanged; digit 0 SHALL never be blanked.
REQ-028 Without SEG_LEADING_ZERO_BLANK_EN, all four digits SHALL always be decoded.

Verification (DIGIT_CYCLES=4, GAP_CYCLES=2 unless stated)
REQ-029 Reset, no load -> ga sequence 1111x2, 1110x4, 1111x2, 1101x4, 1111x2, 1011x4, 1111x2, 0111x4, repeating; seg=1000000 in every DRIVE; frame_tick every 24 cycles.
REQ-030 Load 16'h1238 right after reset -> ready low until the cycle after the first boundary; the next frame shows 8 (0000000) on ga[0] and 1 (1111001) on ga[3].
REQ-031 Second load 16'hFFFF while ready=0 -> ignored; display becomes 16'h1238 only.
REQ-032 With SEG_LEADING_ZERO_BLANK_EN: load 16'h0042 -> digits 3,2 show 1111111, digit1 shows 0011001, digit0 shows 0100100; load 16'h0000 -> digit0 shows 1000000.
REQ-033 rst pulsed during DRIVE of idx=2 with a load pending -> next cycle ga=1111, ready=1; display and pending are cleared.
REQ-034 GAP_CYCLES=0 -> ga 1110, 1101, 1011, 0111 back-to-back, 4 cycles each, never 1111 after the first frame starts.
